ram_sp_ctrl: RTL and testbench

Synchronous controller that acts as the initiator side of the single-port, bidirectional-data RAM bus (`address`, `data` inout, `cs`, `we`, `oe`). It accepts one read or write at a time on a valid/ready request port and sequences the RAM strobes. It owns its half of the tri-state data bus, including turnaround cycles. Read data comes back on a single-cycle response pulse. The block sits between an internal master (CPU/DMA glue) and one instance of the single-port synchronous RAM.

---
 rtl/ram_sp_ctrl_if.sv | 24 ++
 rtl/ram_sp_ctrl.sv | 109 ++++++++++
 tb/tb_ram_sp_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sp_ctrl_if.sv
// Request/response port between an internal master and ram_sp_ctrl.
// The master issues one read or write at a time; reads return on a one-cycle pulse.
interface ram_sp_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_sp_ctrl.sv
// Initiator for a single-port synchronous RAM with a shared tri-state data bus.
// Sequences cs/we/oe per operation and inserts a turnaround cycle after every read.
module ram_sp_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_sp_ctrl_if.slave          req_if,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DATA,
        TURN
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  handshake;
    logic                  cs_d;
    logic                  we_d;
    logic                  oe_d;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Ready is masked by rst_n so it is low throughout reset and high as soon as it releases.
    assign req_if.req_ready = (state_q == IDLE) && rst_n;
    assign handshake        = req_if.req_valid && req_if.req_ready;
    assign busy             = (state_q != IDLE);

    // The bus is driven only in WRITE; mem_we doubles as the drive enable.
    assign mem_data = mem_we ? wdata_q : 'z;

    always_comb begin
        state_d = state_q;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        oe_d    = 1'b0;

        unique case (state_q)
            IDLE:    if (handshake) state_d = req_if.req_we ? WRITE : RD_ADDR;
            WRITE:   state_d = IDLE;
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so the flops present them for the whole state.
        unique case (state_d)
            WRITE: begin
                cs_d = 1'b1;
                we_d = 1'b1;
            end
            RD_ADDR, RD_DATA: begin
                cs_d = 1'b1;
                oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            mem_address <= '0;
            wdata_q     <= '0;
        end else begin
            mem_cs <= cs_d;
            mem_we <= we_d;
            mem_oe <= oe_d;
            if (handshake) begin
                mem_address <= req_if.req_addr;
                wdata_q     <= req_if.req_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_if.rsp_valid <= 1'b0;
            req_if.rsp_rdata <= '0;
        end else begin
            req_if.rsp_valid <= (state_q == RD_DATA);
            if (state_q == RD_DATA) begin
                req_if.rsp_rdata <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Bench for ram_sp_ctrl with a behavioural synchronous RAM on the shared data bus.
// A reference FSM and a read-data queue predict every cycle of controller behaviour.
module tb_ram_sp_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_sp_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic          busy;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_oe;
    logic [AW-1:0] mem_address;
    wire  [DW-1:0] mem_data;

    ram_sp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_if     (bus),
        .busy       (busy),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_oe     (mem_oe)
    );

    // RAM: registers read data on a read strobe, drives the bus whenever cs && oe && !we.
    logic [DW-1:0] ram [256];
    logic [DW-1:0] ram_q;
    wire           ram_drv = mem_cs && mem_oe && !mem_we;
    assign mem_data = ram_drv ? ram_q : 'z;

    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[mem_address] <= mem_data;
        else if (mem_cs && mem_oe) ram_q <= ram[mem_address];
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    typedef enum int {M_IDLE, M_WR, M_RA, M_RD, M_TURN} mstate_t;
    mstate_t       m_state = M_IDLE;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] cur_exp = '0;
    logic [DW-1:0] exp_q [$];
    int            cyc      = 0;
    int            n_acc    = 0;
    int            last_acc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_IDLE;
            m_addr  = '0;
        end else begin
            cyc++;
            case (m_state)
                M_IDLE: if (bus.req_valid) begin
                    n_acc++;
                    last_acc = cyc;
                    m_addr   = bus.req_addr;
                    m_wdata  = bus.req_wdata;
                    if (bus.req_we) m_state = M_WR;
                    else begin
                        exp_q.push_back(cur_exp);
                        m_state = M_RA;
                    end
                end
                M_WR:    m_state = M_IDLE;
                M_RA:    m_state = M_RD;
                M_RD:    m_state = M_TURN;
                default: m_state = M_IDLE;
            endcase
        end
    end

    logic [DW-1:0] last_rdata   = '0;
    logic [DW-1:0] popped       = '0;
    bit            prev_ctrl    = 1'b0;
    bit            prev_ram     = 1'b0;
    bit            ctrl_drv     = 1'b0;
    bit            ram_on       = 1'b0;
    int            rsp_cnt      = 0;
    int            last_rsp_cyc = 0;
    int            we_cyc       = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_rdata = '0;
            prev_ctrl  = 1'b0;
            prev_ram   = 1'b0;
        end else begin
            ctrl_drv = mem_cs && mem_we;
            ram_on   = mem_cs && mem_oe && !mem_we;
            chk("req_ready", bus.req_ready, m_state == M_IDLE);
            chk("busy", busy, m_state != M_IDLE);
            chk("mem_cs", mem_cs, m_state inside {M_WR, M_RA, M_RD});
            chk("mem_we", mem_we, m_state == M_WR);
            chk("mem_oe", mem_oe, m_state inside {M_RA, M_RD});
            chk("mem_address", mem_address, m_addr);
            if (m_state == M_WR) chk("mem_data_write", mem_data, m_wdata);
            chk("bus_contention", {ctrl_drv && ram_on, ctrl_drv && prev_ram, ram_on && prev_ctrl}, 0);
            chk("rsp_valid", bus.rsp_valid, m_state == M_TURN);
            if (bus.rsp_valid) begin
                rsp_cnt++;
                last_rsp_cyc = cyc;
                chk("rsp_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    popped = exp_q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, popped);
                    last_rdata = popped;
                end
            end else begin
                chk("rsp_rdata_hold", bus.rsp_rdata, last_rdata);
            end
            if (mem_we) we_cyc++;
            prev_ctrl = ctrl_drv;
            prev_ram  = ram_on;
        end
    end

    logic [DW-1:0] sh [256];
    int            n_sent = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] e, input bit hold, output int acc);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        cur_exp       = e;
        n_sent++;
        n = 0;
        while (!bus.req_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        acc = last_acc;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int acc;
        int prev_acc;
        int snap;
        bit prev_we;
        logic          rw;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i] <= '0;
            sh[i] = '0;
        end

        tbl[0] = '{1'b1, 8'h00, 8'h11, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 8'h00, 8'h11};
        tbl[2] = '{1'b1, 8'hFF, 8'h22, 8'h00};
        tbl[3] = '{1'b0, 8'hFF, 8'h00, 8'h22};
        tbl[4] = '{1'b1, 8'h7F, 8'h33, 8'h00};
        tbl[5] = '{1'b0, 8'h7F, 8'h00, 8'h33};
        tbl[6] = '{1'b1, 8'h7F, 8'h44, 8'h00};
        tbl[7] = '{1'b1, 8'h00, 8'h55, 8'h00};
        tbl[8] = '{1'b0, 8'h7F, 8'h00, 8'h44};
        tbl[9] = '{1'b0, 8'h00, 8'h00, 8'h55};

        // Outputs during reset, before and after clock edges.
        #2;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {mem_cs, mem_we, mem_oe}, 0);
        chk("rst_mem_address", mem_address, 0);
        tick(2);
        chk("rst_strobes_clocked", {mem_cs, mem_we, mem_oe}, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", bus.req_ready, 1);

        // Write then read back 0x10.
        we_cyc = 0;
        send(1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, acc);
        tick(2);
        chk("write_we_cycles", we_cyc, 1);
        sh[8'h10] = 8'hA5;
        snap = rsp_cnt;
        send(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, acc);
        tick(4);
        chk("read_latency", last_rsp_cyc - acc, 2);
        chk("read_rsp_count", rsp_cnt - snap, 1);
        chk("read_rdata_A5", bus.rsp_rdata, 8'hA5);

        // Back-to-back requests with req_valid held high.
        prev_acc = 0;
        prev_we  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b1, acc);
            if (tbl[i].we) sh[tbl[i].addr] = tbl[i].wdata;
            if (i > 0) chk("accept_spacing", acc - prev_acc, prev_we ? 2 : 4);
            prev_acc = acc;
            prev_we  = tbl[i].we;
        end
        bus.req_valid = 1'b0;
        tick(6);
        chk("table_drained", exp_q.size(), 0);

        // Highest address.
        send(1'b1, 8'hFF, 8'h3C, 8'h00, 1'b0, acc);
        sh[8'hFF] = 8'h3C;
        send(1'b0, 8'hFF, 8'h00, 8'h3C, 1'b0, acc);
        tick(4);
        chk("max_addr_rdata", bus.rsp_rdata, 8'h3C);

        // Asynchronous reset in the middle of RD_DATA.
        send(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, acc);
        snap = rsp_cnt;
        @(posedge clk);
        #2;
        chk("pre_abort_in_rd_data", {mem_cs, mem_we, mem_oe}, 3'b101);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("abort_strobes", {mem_cs, mem_we, mem_oe}, 0);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_rsp_rdata", bus.rsp_rdata, 0);
        chk("abort_busy", busy, 0);
        chk("abort_req_ready", bus.req_ready, 0);
        chk("abort_mem_address", mem_address, 0);
        tick(2);
        chk("abort_no_capture", bus.rsp_rdata, 0);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_after_release", bus.req_ready, 1);
        tick(2);
        chk("abort_no_rsp", rsp_cnt - snap, 0);
        send(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, acc);
        tick(4);
        chk("post_abort_read", bus.rsp_rdata, 8'hA5);

        // Quiet period after a read.
        send(1'b1, 8'h20, 8'h5A, 8'h00, 1'b0, acc);
        sh[8'h20] = 8'h5A;
        send(1'b0, 8'h20, 8'h00, 8'h5A, 1'b0, acc);
        tick(4);
        snap = rsp_cnt;
        tick(20);
        chk("idle_no_rsp", rsp_cnt - snap, 0);
        chk("idle_rdata_hold", bus.rsp_rdata, 8'h5A);
        chk("idle_busy", busy, 0);
        chk("idle_strobes", {mem_cs, mem_we, mem_oe}, 0);

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       ra = 8'h00;
                1:       ra = 8'hFF;
                default: ra = 8'($urandom);
            endcase
            rd = 8'($urandom);
            send(rw, ra, rd, sh[ra], 1'($urandom_range(0, 1)), acc);
            if (rw) sh[ra] = rd;
            if (!bus.req_valid) tick($urandom_range(0, 2));
        end
        bus.req_valid = 1'b0;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick(1);
        chk("random_drained", exp_q.size(), 0);
        chk("accept_count", n_acc, n_sent);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
